// File: rtl/dt_stat_scan.sv
// dt_stat_scan: reads the finished distance map back from the result RAM in
// raster order and reduces it to max value, first max address, foreground
// count and at-or-above-threshold count.
module dt_stat_scan #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        thr,
    output logic              res_rd,
    output logic [ADDR_W-1:0] res_addr,
    input  logic [7:0]        res_di,
    output logic              busy,
    output logic              done,
    output logic [7:0]        max_val,
    output logic [ADDR_W-1:0] max_addr,
    output logic [CNT_W-1:0]  fg_cnt,
    output logic [CNT_W-1:0]  ge_cnt
);

    localparam int                N    = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                vld_q, vld_d;
    logic [ADDR_W-1:0]   adr_dly_q, adr_dly_d;
    logic [7:0]          thr_q, thr_d;
    logic [7:0]          max_val_q, max_val_d;
    logic [ADDR_W-1:0]   max_addr_q, max_addr_d;
    logic [CNT_W-1:0]    fg_q, fg_d;
    logic [CNT_W-1:0]    ge_q, ge_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state: address sweep, read-valid pipe, accumulation, start handling.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        thr_d      = thr_q;
        max_val_d  = max_val_q;
        max_addr_d = max_addr_q;
        fg_d       = fg_q;
        ge_d       = ge_q;
        busy_d     = busy_q;
        done_d     = done_q;
        // RAM data for the address issued last cycle arrives one cycle later,
        // so the valid bit and address tag trail the issued read by one edge.
        vld_d      = rd_q;
        adr_dly_d  = addr_q;

        if (vld_q) begin
            // Strict compare keeps the lowest address on ties.
            if (res_di > max_val_q) begin
                max_val_d  = res_di;
                max_addr_d = adr_dly_q;
            end
            if (res_di != 8'd0) fg_d = fg_q + CNT_W'(1);
            if (res_di >= thr_q) ge_d = ge_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_READ;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    max_val_d  = '0;
                    max_addr_d = '0;
                    fg_d       = '0;
                    ge_d       = '0;
                    thr_d      = thr;
                    rd_d       = 1'b1;
                    addr_d     = '0;
                end
            end
            S_READ: begin
                if (addr_q == LAST) begin
                    state_d = S_DRAIN;
                    rd_d    = 1'b0;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                // Last datum is accumulated on this edge by the block above.
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset aborts a scan and clears everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            vld_q      <= 1'b0;
            adr_dly_q  <= '0;
            thr_q      <= '0;
            max_val_q  <= '0;
            max_addr_q <= '0;
            fg_q       <= '0;
            ge_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            adr_dly_q  <= adr_dly_d;
            thr_q      <= thr_d;
            max_val_q  <= max_val_d;
            max_addr_q <= max_addr_d;
            fg_q       <= fg_d;
            ge_q       <= ge_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign res_rd   = rd_q;
    assign res_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign max_val  = max_val_q;
    assign max_addr = max_addr_q;
    assign fg_cnt   = fg_q;
    assign ge_cnt   = ge_q;

endmodule

// File: tb/tb_dt_stat_scan.sv
// Bench for dt_stat_scan: a 4x4 instance driven from a vector table with a
// result scoreboard, plus a 128x128 instance scanning a synthetic map.
module tb_dt_stat_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Small 4x4 instance
    logic        start_s, rd_s, busy_s, done_s;
    logic [7:0]  thr_s, di_s, maxv_s;
    logic [3:0]  addr_s, maxa_s;
    logic [4:0]  fg_s, ge_s;
    logic [7:0]  mem_s [0:15];

    // Full 128x128 instance
    logic        start_l, rd_l, busy_l, done_l;
    logic [7:0]  thr_l, di_l, maxv_l;
    logic [13:0] addr_l, maxa_l;
    logic [14:0] fg_l, ge_l;
    logic [7:0]  mem_l [0:16383];

    dt_stat_scan #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .CNT_W(5)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .thr(thr_s),
        .res_rd(rd_s), .res_addr(addr_s), .res_di(di_s),
        .busy(busy_s), .done(done_s), .max_val(maxv_s), .max_addr(maxa_s),
        .fg_cnt(fg_s), .ge_cnt(ge_s));

    dt_stat_scan dut_l (
        .clk(clk), .reset(reset), .start(start_l), .thr(thr_l),
        .res_rd(rd_l), .res_addr(addr_l), .res_di(di_l),
        .busy(busy_l), .done(done_l), .max_val(maxv_l), .max_addr(maxa_l),
        .fg_cnt(fg_l), .ge_cnt(ge_l));

    // Registered-read RAM models: data valid the cycle after the address.
    always @(posedge clk) begin
        if (rd_s) di_s <= mem_s[addr_s];
        if (rd_l) di_l <= mem_l[addr_l];
    end

    typedef struct {
        int         sel;
        logic [7:0] thr;
        int         rep;
        int         e_max;
        int         e_addr;
        int         e_fg;
        int         e_ge;
    } vec_t;

    vec_t vecs [5];
    vec_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic load_img(input int sel);
        for (int a = 0; a < 16; a++) begin
            case (sel)
                0:       mem_s[a] = 8'(a);
                1:       mem_s[a] = 8'd0;
                2:       mem_s[a] = (a == 5 || a == 10) ? 8'd7 : 8'd1;
                default: mem_s[a] = 8'(15 - a);
            endcase
        end
    endtask

    task automatic do_scan(input vec_t v);
        int   n;
        bit   sweep_ok;
        vec_t e;
        load_img(v.sel);
        @(negedge clk);
        thr_s   = v.thr;
        start_s = 1'b1;
        exp_q.push_back(v);
        @(posedge clk); #1;
        start_s = 1'b0;
        chk("accept_busy", int'(busy_s), 1);
        chk("accept_done", int'(done_s), 0);
        sweep_ok = 1'b1;
        n = 0;
        while (!done_s && n < 100) begin
            if (n < 16 && (int'(addr_s) != n || !rd_s)) sweep_ok = 1'b0;
            if (n == 16 && (rd_s || addr_s != 4'd0)) sweep_ok = 1'b0;
            start_s = (v.rep > 0 && n == v.rep);
            @(posedge clk); #1;
            n++;
        end
        start_s = 1'b0;
        chk("addr_sweep", int'(sweep_ok), 1);
        chk("done_latency", n, 17);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("max_val",  int'(maxv_s), e.e_max);
            chk("max_addr", int'(maxa_s), e.e_addr);
            chk("fg_cnt",   int'(fg_s),   e.e_fg);
            chk("ge_cnt",   int'(ge_s),   e.e_ge);
        end
    endtask

    function automatic int min4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        if (d < m) m = d;
        return m;
    endfunction

    initial begin
        int n;
        vecs[0] = '{sel: 0, thr: 8'd8, rep: 0, e_max: 15, e_addr: 15, e_fg: 15, e_ge: 8};
        vecs[1] = '{sel: 1, thr: 8'd0, rep: 0, e_max: 0,  e_addr: 0,  e_fg: 0,  e_ge: 16};
        vecs[2] = '{sel: 2, thr: 8'd7, rep: 0, e_max: 7,  e_addr: 5,  e_fg: 16, e_ge: 2};
        vecs[3] = '{sel: 0, thr: 8'd8, rep: 6, e_max: 15, e_addr: 15, e_fg: 15, e_ge: 8};
        vecs[4] = '{sel: 3, thr: 8'd8, rep: 0, e_max: 15, e_addr: 0,  e_fg: 15, e_ge: 8};

        reset = 1'b0; start_s = 1'b0; start_l = 1'b0; thr_s = 8'd0; thr_l = 8'd0;
        load_img(0);
        for (int y = 0; y < 128; y++)
            for (int x = 0; x < 128; x++)
                mem_l[y*128 + x] = (x == 0 || y == 0 || x == 127 || y == 127) ? 8'd0
                                   : 8'(min4(x, y, 127 - x, 127 - y));
        mem_l[8256] = 8'd64;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  int'(busy_s), 0);
        chk("rst_done",  int'(done_s), 0);
        chk("rst_rd",    int'(rd_s),   0);
        chk("rst_maxv",  int'(maxv_s), 0);
        chk("rst_l_any", int'({busy_l, done_l, rd_l, addr_l != 14'd0, fg_l != 15'd0}), 0);
        reset = 1'b1;

        // Table-driven scans, back to back (each later start comes from DONE).
        for (int i = 0; i < 4; i++) do_scan(vecs[i]);

        // Results and done hold while idle in DONE.
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", int'(done_s), 1);
        chk("hold_maxv", int'(maxv_s), 15);
        chk("hold_ge",   int'(ge_s),   8);
        chk("hold_rd",   int'(rd_s),   0);

        // Reset mid-scan aborts; next scan reflects only the new image.
        load_img(2);
        @(negedge clk);
        thr_s = 8'd1; start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_rd",    int'(rd_s),   0);
        chk("mid_rst_addr",  int'(addr_s), 0);
        chk("mid_rst_busy",  int'(busy_s), 0);
        chk("mid_rst_done",  int'(done_s), 0);
        chk("mid_rst_maxv",  int'(maxv_s), 0);
        chk("mid_rst_maxa",  int'(maxa_s), 0);
        chk("mid_rst_fg",    int'(fg_s),   0);
        chk("mid_rst_ge",    int'(ge_s),   0);
        reset = 1'b1;
        do_scan(vecs[4]);

        // Full-size map.
        @(negedge clk);
        thr_l = 8'd1; start_l = 1'b1;
        @(posedge clk); #1;
        start_l = 1'b0;
        n = 0;
        while (!done_l && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("big_latency",  n, 16385);
        chk("big_max_val",  int'(maxv_l), 64);
        chk("big_max_addr", int'(maxa_l), 8256);
        chk("big_fg_cnt",   int'(fg_l),   15876);
        chk("big_ge_cnt",   int'(ge_l),   15876);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
